vote_sequencer: RTL and testbench
=================================

# vote_sequencer

Sequential front end for the five-input 3-of-5 majority voter. It opens a voting round on `start` and collects one ballot from each of five voters over per-voter valid/ack handshakes. It closes the round when the outcome is settled, all five have voted, or a timeout expires, then publishes the majority result with a one-cycle valid pulse. Absent ballots count as 0.

## Interface
- `TIMEOUT`, 16: maximum number of COLLECT cycles per round; legal range 1 to 2^`TW`-1.
- `TW`, 5: width of the collect-cycle counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  opens a round; sampled only in IDLE.
- `vote_valid`  in  5  bit i high means voter i presents a ballot this cycle.
- `vote_value`  in  5  bit i is voter i's ballot; qualified by `vote_valid[i]`.
- `vote_ack`  out  5  registered one-cycle pulse on bit i for the cycle after voter i's ballot is accepted.
- `busy`  out  1  high while in COLLECT or DECIDE.
- `voted_mask`  out  5  bit i set once voter i's ballot is latched; cleared on `start` acceptance.
- `result`  out  1  majority decision of the last round; held until the next `start` is accepted.
- `result_valid`  out  1  one-cycle pulse while in DECIDE.
- `timed_out`  out  1  set when the last round closed by timeout; held like `result`.

## Operation
- States are IDLE, COLLECT and DECIDE.
- IDLE:
  - `busy`=0.
  - When `start`=1: go to COLLECT at the next edge. Clear ballots, `voted_mask`, `result`, `timed_out` and the counter.
  - `vote_valid` is ignored, including in the cycle `start` is sampled.
- COLLECT, each cycle:
  - Voter i is accepted when `vote_valid[i]`=1 and `voted_mask[i]`=0. Any subset of voters may be accepted in the same cycle.
  - On acceptance: `vote_value[i]` is latched into ballot i, `voted_mask[i]` is set and `vote_ack[i]` is pulsed in the next cycle.
  - Re-presentation by a voter already marked in `voted_mask` is ignored, with no ack.
- Tallies: ones = count of latched 1-ballots; zeros = count of latched 0-ballots. Both include ballots accepted in the current cycle and are 3 bits wide.
- Exit conditions, evaluated every COLLECT cycle on the post-accept tallies:
  - Settled: ones>=3 or zeros>=3.
  - Complete: `voted_mask` would be all ones.
  - Timeout: counter == `TIMEOUT`-1.
  - Any condition true: go to DECIDE at the next edge. Otherwise the counter increments.
- At the DECIDE entry edge:
  - `result` = (ones>=3).
  - `timed_out` = timeout condition true and settled condition false. If settled and timeout occur in the same cycle, settled wins and `timed_out`=0.
- DECIDE lasts exactly one cycle: `result_valid`=1, then return to IDLE unconditionally. `start` in DECIDE is ignored.
- `start` in COLLECT is ignored.
- Ballots offered after the settle point get no ack; voters that were never acked must withdraw at round end.
- Reset values: state IDLE; all outputs 0; ballots and counter 0.
- Reset mid-round aborts the round: no `result_valid`, and every pending ack is dropped.

## Timing
- `start` sampled at cycle 0 → COLLECT occupies cycles 1 onward.
- A ballot accepted in cycle n → `vote_ack` high in cycle n+1 only.
- Exit condition true in cycle n → DECIDE in cycle n+1, with `result_valid` high in n+1. `result` and `timed_out` are valid from n+1.
- Best case: all five votes valid in cycle 1 → `result_valid` in cycle 2.
- Worst case: the round closes by timeout after `TIMEOUT` COLLECT cycles → `result_valid` in cycle `TIMEOUT`+1 (cycle 17 at default).
- Minimum start-to-start spacing: next `start` is accepted in the IDLE cycle after DECIDE, i.e. 3 cycles at best.
- `busy` is high from cycle 1 through the DECIDE cycle.

## Test plan
- Reset, then `start` at cycle 0 and `vote_valid`=11111, `vote_value`=10110 in cycle 1:
  - `vote_ack`=11111 in cycle 2.
  - `result_valid`=1, `result`=1, `timed_out`=0 in cycle 2.
  - IDLE in cycle 3.
- Early settle: voters 0,1,2 vote 0 in cycle 1; voter 3 offers in cycle 2:
  - DECIDE in cycle 2, `result`=0.
  - Voter 3 gets no ack; `voted_mask`=00111.
- Timeout, `TIMEOUT`=16: only voters 0 and 4 vote 1, in cycle 3:
  - `result_valid` in cycle 17, `result`=0, `timed_out`=1, `voted_mask`=10001.
- Duplicates and ignored starts:
  - Voter 2 holds `vote_valid` for 4 cycles → exactly one ack pulse.
  - `start` pulsed during COLLECT → no effect on the round in progress.
- Settle on the timeout cycle: third 1-vote lands in cycle 16 with `TIMEOUT`=16 → `result`=1, `timed_out`=0, `result_valid` in cycle 17.
- `rst` asserted in cycle 5 of a round:
  - Next cycle: all outputs 0.
  - No `result_valid` ever appears for the aborted round.
  - A new `start` is accepted normally.

Source files
------------

// File: rtl/vote_sequencer.sv
// vote_sequencer: sequential front end for a five-input 3-of-5 majority voter.
// Opens a round on start, collects one ballot per voter over valid/ack
// handshakes, closes on settle / all-voted / timeout, then publishes the
// majority result with a one-cycle result_valid pulse.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        opens a round (sampled only in IDLE)
//   vote_valid   per-voter ballot presentation
//   vote_value   per-voter ballot value, qualified by vote_valid
//   vote_ack     one-cycle pulse the cycle after a ballot is accepted
//   busy         high while in COLLECT or DECIDE
//   voted_mask   voters whose ballot has been latched this round
//   result       majority decision of the last round
//   result_valid one-cycle pulse in DECIDE
//   timed_out    last round closed by timeout (without settling)
module vote_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] vote_valid,
  input  logic [4:0] vote_value,
  output logic [4:0] vote_ack,
  output logic       busy,
  output logic [4:0] voted_mask,
  output logic       result,
  output logic       result_valid,
  output logic       timed_out
);

  localparam int unsigned NV = 5;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [NV-1:0]  ballots;
  logic [NV-1:0]  ballots_nxt;
  logic [NV-1:0]  mask_nxt;
  logic [NV-1:0]  ack_nxt;
  logic [NV-1:0]  accept;
  logic [TW-1:0]  cnt;
  logic [TW-1:0]  cnt_nxt;
  logic           result_nxt;
  logic           timed_out_nxt;
  logic [CW-1:0]  ones;
  logic [CW-1:0]  zeros;
  logic           settled;
  logic           complete;
  logic           tmo_hit;

  // Population count of a five-bit vector.
  function automatic logic [CW-1:0] pop5(input logic [NV-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(NV); i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-value logic; tallies include this cycle's accepts.
  always_comb begin
    state_nxt     = state;
    ballots_nxt   = ballots;
    mask_nxt      = voted_mask;
    ack_nxt       = '0;
    cnt_nxt       = cnt;
    result_nxt    = result;
    timed_out_nxt = timed_out;
    accept        = '0;
    ones          = '0;
    zeros         = '0;
    settled       = 1'b0;
    complete      = 1'b0;
    tmo_hit       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = COLLECT;
          ballots_nxt   = '0;
          mask_nxt      = '0;
          result_nxt    = 1'b0;
          timed_out_nxt = 1'b0;
          cnt_nxt       = '0;
        end
      end

      COLLECT: begin
        accept      = vote_valid & ~voted_mask;
        mask_nxt    = voted_mask | accept;
        ballots_nxt = (ballots & ~accept) | (vote_value & accept);
        ack_nxt     = accept;
        ones        = pop5(ballots_nxt & mask_nxt);
        zeros       = pop5(~ballots_nxt & mask_nxt);
        settled     = (ones >= CW'(3)) || (zeros >= CW'(3));
        complete    = &mask_nxt;
        tmo_hit     = (cnt == TW'(TIMEOUT - 1));
        if (settled || complete || tmo_hit) begin
          state_nxt     = DECIDE;
          result_nxt    = (ones >= CW'(3));
          // A settle on the timeout cycle is a normal close, not a timeout.
          timed_out_nxt = tmo_hit && !settled;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end

      DECIDE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ballots      <= '0;
      voted_mask   <= '0;
      vote_ack     <= '0;
      cnt          <= '0;
      result       <= 1'b0;
      timed_out    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      ballots      <= ballots_nxt;
      voted_mask   <= mask_nxt;
      vote_ack     <= ack_nxt;
      cnt          <= cnt_nxt;
      result       <= result_nxt;
      timed_out    <= timed_out_nxt;
      busy         <= (state_nxt != IDLE);
      result_valid <= (state_nxt == DECIDE);
    end
  end

endmodule

// File: tb/tb_vote_sequencer.sv
// Self-checking bench for vote_sequencer: round-level behavioural model
// compared every cycle, plus directed rounds with literal expectations.
module tb_vote_sequencer;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TW      = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] vote_valid = '0;
  logic [4:0] vote_value = '0;
  logic [4:0] vote_ack;
  logic       busy;
  logic [4:0] voted_mask;
  logic       result;
  logic       result_valid;
  logic       timed_out;

  int errors = 0;
  int checks = 0;

  vote_sequencer #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_value   (vote_value),
    .vote_ack     (vote_ack),
    .busy         (busy),
    .voted_mask   (voted_mask),
    .result       (result),
    .result_valid (result_valid),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Round-level model: ballot per voter is -1 (absent), 0 or 1.
  int         m_ballot [5] = '{-1, -1, -1, -1, -1};
  int         m_mode   = 0;  // 0 idle, 1 collecting, 2 deciding
  int         m_cycles = 0;  // collect cycles used this round
  logic [4:0] m_ack    = '0;
  logic       m_busy   = 1'b0;
  logic       m_result = 1'b0;
  logic       m_rv     = 1'b0;
  logic       m_tmo    = 1'b0;

  function automatic logic [4:0] model_mask();
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) m[i] = (m_ballot[i] >= 0);
    return m;
  endfunction

  // Model update on each edge, then compare all outputs.
  always @(posedge clk) begin
    int n1, n0, np;
    bit settled_m, timeout_m;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_ballot[i] = -1;
      m_mode = 0; m_cycles = 0; m_ack = '0; m_busy = 0;
      m_result = 0; m_rv = 0; m_tmo = 0;
    end else begin
      case (m_mode)
        0: begin
          m_ack = '0; m_rv = 0;
          if (start) begin
            for (int i = 0; i < 5; i++) m_ballot[i] = -1;
            m_result = 0; m_tmo = 0; m_cycles = 0; m_mode = 1;
          end
          m_busy = (m_mode != 0);
        end
        1: begin
          m_ack = '0;
          for (int i = 0; i < 5; i++) begin
            if (vote_valid[i] && m_ballot[i] < 0) begin
              m_ballot[i] = int'(vote_value[i]);
              m_ack[i] = 1'b1;
            end
          end
          n1 = 0; n0 = 0; np = 0;
          for (int i = 0; i < 5; i++) begin
            if (m_ballot[i] == 1) n1++;
            if (m_ballot[i] == 0) n0++;
            if (m_ballot[i] >= 0) np++;
          end
          m_cycles++;
          settled_m = (n1 >= 3) || (n0 >= 3);
          timeout_m = (m_cycles == int'(TIMEOUT));
          if (settled_m || np == 5 || timeout_m) begin
            m_result = (n1 >= 3);
            m_tmo = timeout_m && !settled_m;
            m_rv = 1;
            m_mode = 2;
          end
          m_busy = 1;
        end
        default: begin
          m_mode = 0; m_rv = 0; m_busy = 0; m_ack = '0;
        end
      endcase
    end
    #1;
    cmp("ack", vote_ack, m_ack);
    cmp("busy", 5'(busy), 5'(m_busy));
    cmp("voted_mask", voted_mask, model_mask());
    cmp("result", 5'(result), 5'(m_result));
    cmp("result_valid", 5'(result_valid), 5'(m_rv));
    cmp("timed_out", 5'(timed_out), 5'(m_tmo));
  end

  // Drive one cycle of inputs; returns in the following cycle, outputs settled.
  task automatic step(input logic r, input logic s, input logic [4:0] vv, input logic [4:0] val);
    @(negedge clk);
    rst = r; start = s; vote_valid = vv; vote_value = val;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    int acks;
    bit seen;

    // Reset state.
    step(1, 0, '0, '0);
    step(1, 0, '0, '0);
    cmp("rst_ack", vote_ack, 5'b00000);
    cmp("rst_busy", 5'(busy), 5'd0);
    cmp("rst_mask", voted_mask, 5'b00000);
    cmp("rst_rv", 5'(result_valid), 5'd0);
    idle(2);

    // All five vote in cycle 1.
    step(0, 1, 5'b11111, 5'b11111);          // cycle 0: start, votes ignored
    cmp("t1_busy_c1", 5'(busy), 5'd1);
    cmp("t1_noack_c1", vote_ack, 5'b00000);
    step(0, 0, 5'b11111, 5'b10110);          // cycle 1
    cmp("t1_ack", vote_ack, 5'b11111);
    cmp("t1_rv", 5'(result_valid), 5'd1);
    cmp("t1_result", 5'(result), 5'd1);
    cmp("t1_tmo", 5'(timed_out), 5'd0);
    step(0, 0, '0, '0);                      // cycle 2 -> cycle 3 idle
    cmp("t1_idle", 5'(busy), 5'd0);
    cmp("t1_rv_low", 5'(result_valid), 5'd0);
    idle(1);

    // Early settle on three zeros; late voter 3 not acked.
    step(0, 1, '0, '0);
    step(0, 0, 5'b00111, 5'b00000);
    cmp("t2_rv", 5'(result_valid), 5'd1);
    cmp("t2_result", 5'(result), 5'd0);
    step(0, 0, 5'b01000, 5'b01000);
    cmp("t2_noack", vote_ack, 5'b00000);
    cmp("t2_mask", voted_mask, 5'b00111);
    idle(1);

    // Timeout with voters 0 and 4 voting 1 in cycle 3.
    step(0, 1, '0, '0);
    idle(2);
    step(0, 0, 5'b10001, 5'b10001);          // cycle 3 -> now cycle 4
    for (int c = 4; c < 17; c++) begin
      cmp("t3_no_early_rv", 5'(result_valid), 5'd0);
      step(0, 0, '0, '0);
    end
    cmp("t3_rv_c17", 5'(result_valid), 5'd1);
    cmp("t3_result", 5'(result), 5'd0);
    cmp("t3_tmo", 5'(timed_out), 5'd1);
    cmp("t3_mask", voted_mask, 5'b10001);
    idle(1);

    // Voter 2 holds valid for 4 cycles; start pulsed mid-round.
    step(0, 1, '0, '0);
    acks = 0;
    for (int c = 1; c <= 4; c++) begin
      step(0, (c == 2), 5'b00100, 5'b00100);
      if (vote_ack[2]) acks++;
    end
    cmp("t4_busy", 5'(busy), 5'd1);
    cmp("t4_mask", voted_mask, 5'b00100);
    seen = 0;
    for (int k = 0; k < 25 && !seen; k++) begin
      step(0, 0, '0, '0);
      if (vote_ack[2]) acks++;
      if (result_valid) seen = 1;
    end
    cmp("t4_rv_seen", 5'(seen), 5'd1);
    cmp("t4_one_ack", 5'(acks), 5'd1);
    cmp("t4_tmo", 5'(timed_out), 5'd1);
    idle(1);

    // Third 1-vote lands on the timeout cycle: settled wins.
    step(0, 1, '0, '0);
    step(0, 0, 5'b00011, 5'b11111);          // cycle 1
    idle(14);                                // cycles 2..15
    step(0, 0, 5'b00100, 5'b00100);          // cycle 16 -> now 17
    cmp("t5_rv", 5'(result_valid), 5'd1);
    cmp("t5_result", 5'(result), 5'd1);
    cmp("t5_tmo", 5'(timed_out), 5'd0);
    idle(1);

    // Reset in cycle 5 of a round.
    step(0, 1, '0, '0);
    step(0, 0, 5'b00001, 5'b00001);
    idle(3);                                 // cycles 2..4
    step(1, 0, '0, '0);                      // cycle 5 -> now 6
    cmp("t6_busy", 5'(busy), 5'd0);
    cmp("t6_mask", voted_mask, 5'b00000);
    cmp("t6_ack", vote_ack, 5'b00000);
    cmp("t6_result", 5'(result), 5'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, '0, '0);
      if (result_valid) seen = 1;
    end
    cmp("t6_no_rv", 5'(seen), 5'd0);
    step(0, 1, '0, '0);
    cmp("t6_restart_busy", 5'(busy), 5'd1);
    step(0, 0, 5'b11111, 5'b00011);
    cmp("t6_restart_rv", 5'(result_valid), 5'd1);
    cmp("t6_restart_result", 5'(result), 5'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
           5'($urandom) & 5'($urandom), 5'($urandom));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
